// File: rtl/control.sv
// Sequencing FSM for the floating-point adder datapath.
//
// The operation runs through five stages after a start request:
// exponent compare/align, normalize, round, an optional renormalize loop,
// and a one-cycle done flag.
//
// Ports:
//   Clock, Reset        rising-edge clock, asynchronous active-low reset
//   Go                  start request, only looked at while idle
//   ExpSet, ExpDiff     exponent-compare result and |expA - expB|
//   FFOValid, FFOIndex  leading-one detector on the raw sum
//   roundedMant         rounded mantissa {carry, hidden, fraction}
//   SelExpMux, SelSRMuxG, SelSRMuxL, ShiftRightEnable, ShiftRightAmount
//                       alignment-stage controls
//   SREn, SLEn, NoShift, ShiftAmount, SelMuxR
//                       normalizer controls
//   FlagResult          result-valid pulse
//
// All outputs are decoded combinationally from the state register and the
// current inputs.
module control #(
  parameter int unsigned EXPBITS      = 8,
  parameter int unsigned MANTISSABITS = 23
) (
  input  logic                            Clock,
  input  logic                            Reset,
  input  logic                            Go,
  input  logic                            ExpSet,
  input  logic [EXPBITS-1:0]              ExpDiff,
  input  logic                            FFOValid,
  input  logic [$clog2(MANTISSABITS)-1:0] FFOIndex,
  input  logic [MANTISSABITS+1:0]         roundedMant,
  output logic                            SelExpMux,
  output logic                            SelSRMuxG,
  output logic                            SelSRMuxL,
  output logic                            ShiftRightEnable,
  output logic [$clog2(2*MANTISSABITS)-1:0] ShiftRightAmount,
  output logic                            SREn,
  output logic                            SLEn,
  output logic [$clog2(MANTISSABITS)-1:0] ShiftAmount,
  output logic                            NoShift,
  output logic                            SelMuxR,
  output logic                            FlagResult
);

  localparam int unsigned NBITS  = $clog2(MANTISSABITS);
  localparam int unsigned NBITSE = $clog2(2 * MANTISSABITS);

  // A shift of MANTISSABITS+2 or more clears the smaller operand entirely.
  localparam logic [EXPBITS-1:0] AlignMax  = EXPBITS'(MANTISSABITS + 2);
  localparam logic [NBITSE-1:0]  AlignMaxS = NBITSE'(MANTISSABITS + 2);

  // Leading one at MANTISSABITS means the sum is already normalized.
  localparam logic [NBITS-1:0] HiddenIdx = NBITS'(MANTISSABITS);
  localparam logic [NBITS-1:0] CarryIdx  = NBITS'(MANTISSABITS + 1);
  localparam logic [NBITS-1:0] OneShift  = NBITS'(1);

  localparam logic [2:0] StIdle   = 3'd0;
  localparam logic [2:0] StAlign  = 3'd1;
  localparam logic [2:0] StNorm   = 3'd2;
  localparam logic [2:0] StRound  = 3'd3;
  localparam logic [2:0] StRenorm = 3'd4;
  localparam logic [2:0] StDone   = 3'd5;

  logic [2:0] state_q, state_d;

  // Only the carry bit of the rounded mantissa steers the sequence.
  logic unused_mant;
  assign unused_mant = ^roundedMant[MANTISSABITS:0];

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:   if (Go) state_d = StAlign;
      StAlign:  state_d = StNorm;
      StNorm:   state_d = StRound;
      // A carry out of rounding needs one more right shift, which may in
      // turn carry again; the loop has no iteration limit.
      StRound:  state_d = roundedMant[MANTISSABITS+1] ? StRenorm : StDone;
      StRenorm: state_d = StRound;
      StDone:   state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_comb begin
    SelExpMux        = 1'b0;
    SelSRMuxG        = 1'b0;
    SelSRMuxL        = 1'b0;
    ShiftRightEnable = 1'b0;
    ShiftRightAmount = '0;
    SREn             = 1'b0;
    SLEn             = 1'b0;
    ShiftAmount      = '0;
    NoShift          = 1'b0;
    SelMuxR          = 1'b0;
    FlagResult       = 1'b0;
    case (state_q)
      StAlign: begin
        SelExpMux        = ExpSet;
        SelSRMuxG        = ExpSet;
        SelSRMuxL        = ~ExpSet;
        ShiftRightEnable = (ExpDiff != '0);
        ShiftRightAmount = (ExpDiff > AlignMax) ? AlignMaxS : ExpDiff[NBITSE-1:0];
      end
      StNorm: begin
        if (!FFOValid) begin
          NoShift = 1'b1;
        end else if (FFOIndex >= CarryIdx) begin
          SREn        = 1'b1;
          ShiftAmount = OneShift;
        end else if (FFOIndex == HiddenIdx) begin
          NoShift = 1'b1;
        end else begin
          SLEn        = 1'b1;
          ShiftAmount = HiddenIdx - FFOIndex;
        end
      end
      StRenorm: begin
        SelMuxR     = 1'b1;
        SREn        = 1'b1;
        ShiftAmount = OneShift;
      end
      StDone: begin
        FlagResult = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_control.sv
module tb_control;

  logic        Clock = 1'b0;
  logic        Reset;
  logic        Go;
  logic        ExpSet;
  logic [7:0]  ExpDiff;
  logic        FFOValid;
  logic [4:0]  FFOIndex;
  logic [24:0] roundedMant;
  logic        SelExpMux, SelSRMuxG, SelSRMuxL, ShiftRightEnable;
  logic [5:0]  ShiftRightAmount;
  logic        SREn, SLEn, NoShift, SelMuxR, FlagResult;
  logic [4:0]  ShiftAmount;

  control #(
    .EXPBITS      (8),
    .MANTISSABITS (23)
  ) dut (
    .Clock            (Clock),
    .Reset            (Reset),
    .Go               (Go),
    .ExpSet           (ExpSet),
    .ExpDiff          (ExpDiff),
    .FFOValid         (FFOValid),
    .FFOIndex         (FFOIndex),
    .roundedMant      (roundedMant),
    .SelExpMux        (SelExpMux),
    .SelSRMuxG        (SelSRMuxG),
    .SelSRMuxL        (SelSRMuxL),
    .ShiftRightEnable (ShiftRightEnable),
    .ShiftRightAmount (ShiftRightAmount),
    .SREn             (SREn),
    .SLEn             (SLEn),
    .ShiftAmount      (ShiftAmount),
    .NoShift          (NoShift),
    .SelMuxR          (SelMuxR),
    .FlagResult       (FlagResult)
  );

  always #5 Clock = ~Clock;

  typedef struct packed {
    logic       sel_exp;
    logic       sel_g;
    logic       sel_l;
    logic       sre;
    logic [5:0] sra;
    logic       sren;
    logic       slen;
    logic [4:0] amt;
    logic       noshift;
    logic       selr;
    logic       flag;
  } outv_t;

  typedef struct {
    outv_t      exp;
    logic [1:0] rm;
  } step_t;

  step_t sb[$];
  int    n_checks = 0;
  int    n_pass   = 0;

  function automatic outv_t dut_out();
    outv_t o;
    o.sel_exp = SelExpMux;
    o.sel_g   = SelSRMuxG;
    o.sel_l   = SelSRMuxL;
    o.sre     = ShiftRightEnable;
    o.sra     = ShiftRightAmount;
    o.sren    = SREn;
    o.slen    = SLEn;
    o.amt     = ShiftAmount;
    o.noshift = NoShift;
    o.selr    = SelMuxR;
    o.flag    = FlagResult;
    return o;
  endfunction

  // Reference model of each state's output decode.
  function automatic outv_t exp_align(logic es, logic [7:0] diff);
    outv_t o = '0;
    int    d = int'(diff);
    o.sel_exp = es;
    o.sel_g   = es;
    o.sel_l   = !es;
    o.sre     = (d != 0);
    o.sra     = 6'((d > 25) ? 25 : d);
    return o;
  endfunction

  function automatic outv_t exp_norm(logic valid, logic [4:0] idx);
    outv_t o = '0;
    int    i = int'(idx);
    if (!valid) o.noshift = 1'b1;
    else if (i >= 24) begin
      o.sren = 1'b1;
      o.amt  = 5'd1;
    end else if (i == 23) o.noshift = 1'b1;
    else begin
      o.slen = 1'b1;
      o.amt  = 5'(23 - i);
    end
    return o;
  endfunction

  function automatic outv_t exp_renorm();
    outv_t o = '0;
    o.selr = 1'b1;
    o.sren = 1'b1;
    o.amt  = 5'd1;
    return o;
  endfunction

  function automatic outv_t exp_done();
    outv_t o = '0;
    o.flag = 1'b1;
    return o;
  endfunction

  // One full operation: expected per-cycle outputs are queued as the request
  // is issued, then popped and compared cycle by cycle. rm_seq holds the
  // roundedMant MSB pair for each ROUND visit, lowest pair first.
  task automatic run_op(input string name, input logic es, input logic [7:0] diff,
                        input logic valid, input logic [4:0] idx,
                        input logic [7:0] rm_seq, input int n_round, input logic go_hold);
    step_t s;
    outv_t got;
    int    cyc;
    @(negedge Clock);
    Go = 1'b1; ExpSet = es; ExpDiff = diff; FFOValid = valid; FFOIndex = idx;
    roundedMant = '0;
    #1;
    got = dut_out();
    n_checks++;
    if (got !== '0) $display("FAIL %s idle: got %h expected 0", name, got);
    else n_pass++;

    s.rm = 2'b00;
    s.exp = exp_align(es, diff); sb.push_back(s);
    s.exp = exp_norm(valid, idx); sb.push_back(s);
    for (int k = 0; k < n_round; k++) begin
      s.rm = rm_seq[2*k +: 2];
      s.exp = '0; sb.push_back(s);
      if (s.rm[1]) begin
        s.rm = 2'b00;
        s.exp = exp_renorm(); sb.push_back(s);
      end
    end
    s.rm = 2'b00;
    s.exp = exp_done(); sb.push_back(s);
    s.exp = '0; sb.push_back(s);

    cyc = 1;
    while (sb.size() > 0) begin
      @(posedge Clock); #1;
      s = sb.pop_front();
      Go = go_hold;
      roundedMant = {s.rm, 23'($urandom)};
      #1;
      got = dut_out();
      n_checks++;
      if (got !== s.exp)
        $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, got, s.exp);
      else n_pass++;
      cyc++;
    end
  endtask

  task automatic test_reset();
    outv_t got;
    Reset = 1'b0; Go = 1'b1; ExpSet = 1'b1; ExpDiff = 8'h10; FFOValid = 1'b1;
    FFOIndex = 5'd5; roundedMant = '1;
    repeat (2) @(posedge Clock);
    #1;
    got = dut_out();
    n_checks++;
    if (got !== '0) $display("FAIL reset_outputs: got %h expected 0", got);
    else n_pass++;
    @(negedge Clock);
    Go = 1'b0;
    Reset = 1'b1;
    @(posedge Clock); #1;
    got = dut_out();
    n_checks++;
    if (got !== '0) $display("FAIL idle_no_go: got %h expected 0", got);
    else n_pass++;
  endtask

  task automatic test_clamp();
    run_op("clamp_85", 1'b1, 8'h55, 1'b1, 5'd23, 8'b01, 1, 1'b0);
  endtask

  task automatic test_renorm_once();
    run_op("renorm_once", 1'b0, 8'h05, 1'b1, 5'd22, 8'b01_10, 2, 1'b0);
  endtask

  task automatic test_carry_out();
    run_op("carry_out", 1'b1, 8'h00, 1'b1, 5'd24, 8'b01, 1, 1'b0);
  endtask

  task automatic test_zero_sum();
    run_op("zero_sum", 1'b0, 8'h03, 1'b0, 5'd23, 8'b00, 1, 1'b0);
  endtask

  task automatic test_renorm_twice();
    run_op("renorm_twice", 1'b1, 8'h01, 1'b1, 5'd10, 8'b01_11_10, 3, 1'b0);
  endtask

  task automatic test_boundaries();
    run_op("diff_24", 1'b1, 8'd24, 1'b1, 5'd0, 8'b00, 1, 1'b0);
    run_op("diff_25", 1'b0, 8'd25, 1'b1, 5'd31, 8'b00, 1, 1'b0);
    run_op("diff_26", 1'b1, 8'd26, 1'b1, 5'd25, 8'b00, 1, 1'b0);
    run_op("diff_255", 1'b0, 8'hFF, 1'b1, 5'd1, 8'b00, 1, 1'b0);
  endtask

  // Go held high throughout: ignored mid-operation, restarts right after idle.
  task automatic test_back_to_back();
    run_op("b2b_first", 1'b1, 8'h07, 1'b1, 5'd20, 8'b00, 1, 1'b1);
    run_op("b2b_second", 1'b0, 8'h02, 1'b1, 5'd23, 8'b01_10, 2, 1'b0);
  endtask

  task automatic test_reset_mid();
    outv_t got;
    outv_t want;
    @(negedge Clock);
    Go = 1'b1; ExpSet = 1'b1; ExpDiff = 8'h04; FFOValid = 1'b1; FFOIndex = 5'd22;
    roundedMant = '0;
    @(posedge Clock); #1;
    Go = 1'b0;
    @(posedge Clock); #1;
    got = dut_out();
    want = exp_norm(1'b1, 5'd22);
    n_checks++;
    if (got !== want) $display("FAIL mid_norm: got %h expected %h", got, want);
    else n_pass++;
    Reset = 1'b0;
    #1;
    got = dut_out();
    n_checks++;
    if (got !== '0) $display("FAIL mid_reset_async: got %h expected 0", got);
    else n_pass++;
    @(posedge Clock); #1;
    @(negedge Clock);
    Reset = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(posedge Clock); #1;
      got = dut_out();
      n_checks++;
      if (got !== '0) $display("FAIL after_abort cycle %0d: got %h expected 0", k, got);
      else n_pass++;
    end
    run_op("restart", 1'b0, 8'h09, 1'b1, 5'd23, 8'b00, 1, 1'b0);
  endtask

  initial begin
    test_reset();
    test_clamp();
    test_renorm_once();
    test_carry_out();
    test_zero_sum();
    test_renorm_twice();
    test_boundaries();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
